serial_frame_gen: RTL and testbench
===================================

# serial_frame_gen

Synthesizable serial source that produces the single-bit `DIN` stream consumed by `DATA_CONVERT`. It runs in the 30 MHz domain and first emits a sync preamble. It then sends bytes from a valid/ready byte interface as 10-bit frames: start `1`, 8 data bits MSB first, stop `0`. It re-emits the preamble after every `SYNC_FRAMES` frames. It replaces the behavioural stimulus so the converter can be exercised on silicon and in gate-level sim.

## Interface
Parameters:
- `PRE_ZEROS`, 39 — preamble zero-run length in bits (1..63)
- `PRE_ONES`, 9 — preamble one-run length in bits (1..63)
- `SYNC_FRAMES`, 960 — frames between preambles (1..1023)
- `PAT_LEN`, 240 — test-pattern wrap length (1..256)

Ports:
- `CLK_30MHZ`  in  1  bit clock; every bit lasts one cycle
- `RSTN`  in  1  reset; synchronous and active-low
- `DATA`  in  8  byte to send
- `DATA_VALID`  in  1  `DATA` is valid
- `DATA_READY`  out  1  byte is accepted on the edge where `DATA_VALID && DATA_READY`
- `PAT_EN`  in  1  selects the internal pattern source (see Configuration)
- `DIN`  out  1  serial line, registered
- `IN_SYNC`  out  1  high while preamble bits are on `DIN`
- `FRAME_DONE`  out  1  one-cycle pulse coincident with each stop bit on `DIN`

## Operation
- States: `PRE0`, `PRE1`, `IDLE`, `START`, `DATA`, `STOP`.
- `PRE0`: drives `DIN=0` for `PRE_ZEROS` cycles, then goes to `PRE1`.
- `PRE1`: drives `DIN=1` for `PRE_ONES` cycles. On its last cycle it clears the frame counter and goes to `IDLE` or `START`, per the accept rule.
- `IDLE`: drives `DIN=0` (line idles low, same level as stop).
- `START`: drives `DIN=1` for 1 cycle.
- `DATA`: drives `DIN` = shift register MSB for 8 cycles, shifting left each cycle.
- `STOP`: drives `DIN=0` for 1 cycle and increments the 10-bit frame counter.
- Accept rule:
  - `DATA_READY=1` in `IDLE`, on the last cycle of `PRE1`, and in `STOP` when the incremented frame count is less than `SYNC_FRAMES`. It is 0 otherwise.
  - On accept, `DATA` loads the shift register and the next state is `START`.
  - With no accept, the next state is `IDLE`.
- After `STOP`, if the frame count reaches `SYNC_FRAMES`, the next state is `PRE0` and the frame counter clears. `DATA_READY` stays 0 until the last cycle of `PRE1`.
- `IN_SYNC=1` exactly in `PRE0`/`PRE1`.
- `FRAME_DONE=1` exactly in `STOP`.
- A byte that is presented but not accepted is left untouched; there is no internal buffering beyond the shift register.

## Timing
- Reset values (the cycle after `RSTN` is sampled low):
  - `DIN=0`, `DATA_READY=0`, `IN_SYNC=1`, `FRAME_DONE=0`
  - state `PRE0`, all counters 0, pattern counter 0
- Reset mid-frame aborts immediately; the partial frame is never completed.
- Outputs are all registered.
- Latency: accept edge, then the start bit on `DIN` in the next cycle, then data bit 7 one cycle later.
- Frame period: 10 cycles. Back-to-back frames have no gap when `DATA_VALID` is held high; throughput is 1 byte per 10 cycles.
- The first frame's start bit immediately follows the last preamble one. With defaults, the line shows 39 zeros, then 10 consecutive ones, then the MSB of the first byte.
- Preamble length: `PRE_ZEROS + PRE_ONES` cycles (48 with defaults).
- `DATA_VALID` deasserting while `DATA_READY=1` is legal; no accept occurs.

## Configuration
- `SERIAL_FRAME_GEN_PATTERN_EN` defined:
  - When `PAT_EN=1`, the byte source is an internal 8-bit counter and `DATA`/`DATA_VALID` are ignored (treated as always valid).
  - The counter loads on each accept, post-increments, and wraps from `PAT_LEN-1` to 0.
  - The counter resets to 0 on reset only; it is not cleared by a preamble.
  - `DATA_READY` still reports accept slots.
- Undefined: `PAT_EN` is ignored, the pattern logic is absent, and the external byte interface is always used.

## Test plan
- Reset release with `DATA_VALID=1`, `DATA=8'hA5` -> `DIN` = 39×0, 9×1, then `1101001010` repeating. `IN_SYNC` is high for the first 48 cycles. `FRAME_DONE` pulses every 10 cycles.
- `DATA_VALID=0` after the preamble -> `DIN` held 0 with `DATA_READY=1`. Assert `DATA_VALID` with `8'h3C` -> start bit on the next cycle, then `00111100`, then 0.
- `SYNC_FRAMES=4` with continuous valid -> after the 4th stop bit, a 48-cycle preamble follows. `DATA_READY=0` from that stop bit until the last `PRE1` cycle.
- `RSTN` low during data bit 4 -> the next cycle shows `DIN=0`, `DATA_READY=0`, `IN_SYNC=1`. After release, the full 48-cycle preamble restarts.
- `DATA_VALID` rising exactly on the `STOP` cycle -> accepted there. The start bit directly follows the stop bit with no idle cycle.
- Macro defined, `PAT_EN=1`, `PAT_LEN=240` -> frame payloads 0,1,…,239,0,1,… The sequence continues across a preamble without reset.

Source files
------------

// File: rtl/serial_frame_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_frame_gen_if                                                  |
// | Valid/ready byte channel feeding the serial frame generator.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface serial_frame_gen_if;
  logic [7:0] DATA;
  logic       DATA_VALID;
  logic       DATA_READY;

  modport master (output DATA, output DATA_VALID, input DATA_READY);
  modport slave  (input DATA, input DATA_VALID, output DATA_READY);
endinterface
`default_nettype wire

// File: rtl/serial_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_frame_gen                                                     |
// | Sync preamble plus 10-bit framed byte stream on DIN (30 MHz domain). |
// | Optional internal byte counter source: SERIAL_FRAME_GEN_PATTERN_EN.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_frame_gen #(
  parameter int PRE_ZEROS   = 39,
  parameter int PRE_ONES    = 9,
  parameter int SYNC_FRAMES = 960,
  parameter int PAT_LEN     = 240
) (
  input  logic                     CLK_30MHZ,
  input  logic                     RSTN,
  serial_frame_gen_if.slave        byte_if,
  input  logic                     PAT_EN,
  output logic                     DIN,
  output logic                     IN_SYNC,
  output logic                     FRAME_DONE
);

  localparam logic [5:0]  ZEROS_LAST = 6'(PRE_ZEROS - 1);
  localparam logic [5:0]  ONES_LAST  = 6'(PRE_ONES - 1);
  localparam logic [10:0] SYNC_LIMIT = 11'(SYNC_FRAMES);

  typedef enum logic [2:0] {
    S_PRE0  = 3'd0,
    S_PRE1  = 3'd1,
    S_IDLE  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [9:0]  frame_cnt, frame_n;
  logic [7:0]  shreg, shreg_n;
  logic        ready, ready_n;
  logic        din_n, in_sync_n, frame_done_n;
  logic [10:0] frame_inc, frame_n_inc;
  logic        accept;
  logic        src_valid;
  logic [7:0]  src_byte;

`ifdef SERIAL_FRAME_GEN_PATTERN_EN
  localparam logic [7:0] PAT_LAST = 8'(PAT_LEN - 1);
  logic [7:0] pat_cnt;

  assign src_valid = PAT_EN ? 1'b1 : byte_if.DATA_VALID;
  assign src_byte  = PAT_EN ? pat_cnt : byte_if.DATA;

  // Survives preambles on purpose: only reset restarts the pattern.
  always_ff @(posedge CLK_30MHZ) begin
    if (!RSTN) begin
      pat_cnt <= '0;
    end else if (accept && PAT_EN) begin
      pat_cnt <= (pat_cnt == PAT_LAST) ? 8'd0 : pat_cnt + 8'd1;
    end
  end
`else
  logic unused_pat_en;
  assign unused_pat_en = PAT_EN;
  assign src_valid     = byte_if.DATA_VALID;
  assign src_byte      = byte_if.DATA;
`endif

  assign accept             = src_valid && ready;
  assign byte_if.DATA_READY = ready;
  assign frame_inc          = {1'b0, frame_cnt} + 11'd1;
  assign frame_n_inc        = {1'b0, frame_n} + 11'd1;

  always_ff @(posedge CLK_30MHZ) begin
    if (!RSTN) begin
      state      <= S_PRE0;
      cnt        <= '0;
      frame_cnt  <= '0;
      shreg      <= '0;
      ready      <= 1'b0;
      DIN        <= 1'b0;
      IN_SYNC    <= 1'b1;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      frame_cnt  <= frame_n;
      shreg      <= shreg_n;
      ready      <= ready_n;
      DIN        <= din_n;
      IN_SYNC    <= in_sync_n;
      FRAME_DONE <= frame_done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    frame_n = frame_cnt;
    shreg_n = shreg;
    case (state)
      S_PRE0: begin
        if (cnt == ZEROS_LAST) begin
          state_n = S_PRE1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      S_PRE1: begin
        if (cnt == ONES_LAST) begin
          cnt_n   = '0;
          frame_n = '0;
          if (accept) begin
            state_n = S_START;
            shreg_n = src_byte;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          state_n = S_START;
          shreg_n = src_byte;
        end
      end
      S_START: begin
        state_n = S_DATA;
        cnt_n   = '0;
      end
      S_DATA: begin
        shreg_n = {shreg[6:0], 1'b0};
        if (cnt == 6'd7) begin
          state_n = S_STOP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      S_STOP: begin
        if (frame_inc >= SYNC_LIMIT) begin
          state_n = S_PRE0;
          cnt_n   = '0;
          frame_n = '0;
        end else begin
          frame_n = frame_inc[9:0];
          if (accept) begin
            state_n = S_START;
            shreg_n = src_byte;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_PRE0;
        cnt_n   = '0;
        frame_n = '0;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    din_n        = (state_n == S_PRE1) || (state_n == S_START) ||
                   ((state_n == S_DATA) && shreg_n[7]);
    in_sync_n    = (state_n == S_PRE0) || (state_n == S_PRE1);
    frame_done_n = (state_n == S_STOP);
    ready_n      = (state_n == S_IDLE) ||
                   ((state_n == S_PRE1) && (cnt_n == ONES_LAST)) ||
                   ((state_n == S_STOP) && (frame_n_inc < SYNC_LIMIT));
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_frame_gen                                                  |
// | Scoreboard bench: accepted bytes are queued and matched on DIN.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_serial_frame_gen;
  localparam int SYNC    = 4;
  localparam int PRE_Z   = 39;
  localparam int PRE_O   = 9;
  localparam int PRE_LEN = PRE_Z + PRE_O;
  localparam int PLEN    = 240;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic pat_en = 1'b0;
  logic din, in_sync, frame_done;

  serial_frame_gen_if bus ();

  serial_frame_gen #(
    .PRE_ZEROS(PRE_Z), .PRE_ONES(PRE_O), .SYNC_FRAMES(SYNC), .PAT_LEN(PLEN)
  ) dut (
    .CLK_30MHZ(clk), .RSTN(rstn), .byte_if(bus), .PAT_EN(pat_en),
    .DIN(din), .IN_SYNC(in_sync), .FRAME_DONE(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int cur_ph = 0;      // 0 idle, 1 start, 2..9 data, 10 stop, 11 preamble
  int pre_pos = 0;
  int fcount = 0;
  int frames_seen = 0;
  logic [7:0] rx_sh = 8'd0;
  logic [7:0] pat_exp = 8'd0;

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      logic acc;
      logic rst_edge;
      logic [7:0] accb;
      logic [7:0] got;
      rst_edge = !rstn;
      acc  = rstn && bus.DATA_VALID && bus.DATA_READY;
      accb = bus.DATA;
`ifdef SERIAL_FRAME_GEN_PATTERN_EN
      if (pat_en) begin
        acc  = rstn && bus.DATA_READY;
        accb = pat_exp;
      end
`endif
      @(posedge clk); #1;
      if (rst_edge) begin
        exp_q.delete();
        pre_pos = 0; fcount = 0; cur_ph = 0; pat_exp = 8'd0;
      end
      if (acc) begin
        exp_q.push_back(accb);
`ifdef SERIAL_FRAME_GEN_PATTERN_EN
        if (pat_en) pat_exp = (pat_exp == 8'(PLEN - 1)) ? 8'd0 : pat_exp + 8'd1;
`endif
      end
      if (cur_ph >= 1 && cur_ph <= 9) cur_ph = cur_ph + 1;
      else if (acc) cur_ph = 1;
      else if (pre_pos < PRE_LEN) cur_ph = 11;
      else cur_ph = 0;

      checks++;
      if (cur_ph != 10 && frame_done !== 1'b0) begin
        errors++; $display("FAIL frame_done_spurious ph %0d: got %b expected 0", cur_ph, frame_done);
      end
      checks++;
      if (in_sync !== (cur_ph == 11)) begin
        errors++; $display("FAIL in_sync ph %0d: got %b expected %b", cur_ph, in_sync, cur_ph == 11);
      end
      if (cur_ph == 11) begin
        checks++;
        if (din !== (pre_pos >= PRE_Z)) begin
          errors++; $display("FAIL preamble_din pos %0d: got %b expected %b", pre_pos, din, pre_pos >= PRE_Z);
        end
        checks++;
        if (bus.DATA_READY !== (pre_pos == PRE_LEN - 1)) begin
          errors++; $display("FAIL preamble_ready pos %0d: got %b expected %b", pre_pos, bus.DATA_READY, pre_pos == PRE_LEN - 1);
        end
        pre_pos++;
      end else if (cur_ph == 0) begin
        checks++;
        if (din !== 1'b0 || bus.DATA_READY !== 1'b1) begin
          errors++; $display("FAIL idle_line: got din=%b ready=%b expected din=0 ready=1", din, bus.DATA_READY);
        end
      end else if (cur_ph <= 9) begin
        if (cur_ph >= 2) rx_sh = {rx_sh[6:0], din};
        checks++;
        if ((cur_ph == 1 && din !== 1'b1) || bus.DATA_READY !== 1'b0) begin
          errors++; $display("FAIL frame_body ph %0d: got din=%b ready=%b expected ready=0", cur_ph, din, bus.DATA_READY);
        end
      end else begin
        checks++;
        if (din !== 1'b0 || frame_done !== 1'b1 || bus.DATA_READY !== (fcount + 1 < SYNC)) begin
          errors++; $display("FAIL stop_bit: got din=%b done=%b ready=%b expected din=0 done=1 ready=%b",
                             din, frame_done, bus.DATA_READY, fcount + 1 < SYNC);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL payload: got %02h expected none queued", rx_sh);
        end else begin
          got = exp_q.pop_front();
          if (rx_sh !== got) begin
            errors++; $display("FAIL payload: got %02h expected %02h", rx_sh, got);
          end
        end
        frames_seen++;
        fcount++;
        if (fcount == SYNC) begin
          fcount = 0;
          pre_pos = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.DATA_VALID = 1'b1; bus.DATA = 8'hA5; rstn = 1'b0;
    run(3);
    checks++;
    if (din !== 1'b0 || in_sync !== 1'b1 || bus.DATA_READY !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got din=%b sync=%b ready=%b done=%b expected 0 1 0 0",
                         din, in_sync, bus.DATA_READY, frame_done);
    end
  endtask

  task automatic test_a5_stream();
    logic [57:0] got;
    logic [57:0] expv;
    logic [9:0]  fr;
    int base;
    fr = 10'b1101001010;
    got = '0; expv = '0;
    rstn = 1'b1;
    // The reset cycle already showed preamble bit 0.
    expv = {expv[56:0], 1'b0};
    got  = {got[56:0], din};
    for (int i = 1; i < 58; i++) begin
      run(1);
      got  = {got[56:0], din};
      expv = {expv[56:0], (i < PRE_Z) ? 1'b0 : (i < PRE_LEN) ? 1'b1 : fr[9 - (i - PRE_LEN)]};
    end
    checks++;
    if (got !== expv) begin
      errors++; $display("FAIL a5_bitstream: got %015h expected %015h", got, expv);
    end
    base = frames_seen;
    run(30);
    checks++;
    if (frames_seen - base != 3) begin
      errors++; $display("FAIL a5_frame_rate: got %0d expected 3", frames_seen - base);
    end
    run(1);
    checks++;
    if (in_sync !== 1'b1) begin
      errors++; $display("FAIL a5_resync: got %b expected 1", in_sync);
    end
    run(60);
  endtask

  task automatic test_idle_byte();
    logic [8:0] bits;
    bus.DATA_VALID = 1'b0; rstn = 1'b0;
    run(2);
    rstn = 1'b1;
    run(PRE_LEN + 6);
    checks++;
    if (din !== 1'b0 || bus.DATA_READY !== 1'b1 || in_sync !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got din=%b ready=%b sync=%b expected 0 1 0", din, bus.DATA_READY, in_sync);
    end
    bus.DATA_VALID = 1'b1; bus.DATA = 8'h3C;
    run(1);
    bus.DATA_VALID = 1'b0;
    checks++;
    if (din !== 1'b1) begin
      errors++; $display("FAIL idle_start_latency: got %b expected 1", din);
    end
    bits = '0;
    for (int i = 0; i < 9; i++) begin
      run(1);
      bits = {bits[7:0], din};
    end
    checks++;
    if (bits !== 9'b001111000) begin
      errors++; $display("FAIL idle_3c_bits: got %09b expected 001111000", bits);
    end
    run(3);
  endtask

  task automatic test_sync_frames();
    int ns;
    ns = 0;
    bus.DATA_VALID = 1'b1; rstn = 1'b0;
    run(1);
    rstn = 1'b1;
    for (int c = 0; c < 140; c++) begin
      if (c % 10 == 0) bus.DATA = 8'($urandom);
      run(1);
      if (in_sync === 1'b1) ns++;
    end
    checks++;
    if (ns != 2 * PRE_LEN - 1) begin
      errors++; $display("FAIL sync_preamble_cycles: got %0d expected %0d", ns, 2 * PRE_LEN - 1);
    end
  endtask

  task automatic test_mid_reset();
    int w;
    int ns;
    w = 0; ns = 0;
    bus.DATA_VALID = 1'b1; bus.DATA = 8'h96;
    while (cur_ph != 5 && w < 200) begin
      run(1);
      w++;
    end
    checks++;
    if (cur_ph != 5) begin
      errors++; $display("FAIL midreset_wait: got phase %0d expected 5 (timeout)", cur_ph);
    end
    rstn = 1'b0;
    run(1);
    rstn = 1'b1;
    checks++;
    if (din !== 1'b0 || bus.DATA_READY !== 1'b0 || in_sync !== 1'b1) begin
      errors++; $display("FAIL midreset_abort: got din=%b ready=%b sync=%b expected 0 0 1", din, bus.DATA_READY, in_sync);
    end
    for (int i = 0; i < 60; i++) begin
      run(1);
      if (in_sync === 1'b1) ns++;
    end
    checks++;
    if (ns != PRE_LEN - 1) begin
      errors++; $display("FAIL midreset_preamble: got %0d expected %0d", ns, PRE_LEN - 1);
    end
  endtask

  task automatic test_stop_accept();
    int w;
    w = 0;
    bus.DATA_VALID = 1'b0; rstn = 1'b0;
    run(1);
    rstn = 1'b1;
    run(50);
    bus.DATA_VALID = 1'b1; bus.DATA = 8'hC3;
    run(1);
    bus.DATA_VALID = 1'b0;
    while (cur_ph != 10 && w < 20) begin
      run(1);
      w++;
    end
    checks++;
    if (cur_ph != 10) begin
      errors++; $display("FAIL stop_wait: got phase %0d expected 10 (timeout)", cur_ph);
    end
    bus.DATA_VALID = 1'b1; bus.DATA = 8'h5A;
    run(1);
    bus.DATA_VALID = 1'b0;
    checks++;
    if (din !== 1'b1 || in_sync !== 1'b0) begin
      errors++; $display("FAIL stop_accept_start: got din=%b sync=%b expected 1 0", din, in_sync);
    end
    run(14);
  endtask

`ifdef SERIAL_FRAME_GEN_PATTERN_EN
  task automatic test_pattern();
    int base;
    bus.DATA_VALID = 1'b0; bus.DATA = 8'hFF; pat_en = 1'b1; rstn = 1'b0;
    run(1);
    rstn = 1'b1;
    base = frames_seen;
    run(5600);
    checks++;
    if (frames_seen - base < PLEN + 1) begin
      errors++; $display("FAIL pattern_wrap_count: got %0d expected at least %0d", frames_seen - base, PLEN + 1);
    end
    pat_en = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.DATA = 8'h00;
    bus.DATA_VALID = 1'b0;
    test_reset();
    test_a5_stream();
    test_idle_byte();
    test_sync_frames();
    test_mid_reset();
    test_stop_accept();
`ifdef SERIAL_FRAME_GEN_PATTERN_EN
    test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
